// File: rtl/seu_chain_ctrl.sv
// SEU characterization sequencer: loads a known pattern into a flop chain, holds it for an
// exposure window, then shifts it out and counts bit mismatches against the same pattern.
module seu_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       pattern_sel,
  input  logic [15:0]      hold_cycles,
  output logic             chain_se,
  output logic             chain_si,
  input  logic             chain_so,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat
);

  localparam int unsigned    KW     = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [KW-1:0]  KLast  = KW'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StHold   = 3'd2;
  localparam logic [2:0] StUnload = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // Only the two low index bits ever select a pattern bit.
  function automatic logic pattern_bit(input logic [1:0] sel, input logic [1:0] klo);
    logic b;
    case (sel)
      2'd0:    b = 1'b0;
      2'd1:    b = 1'b1;
      2'd2:    b = klo[0];
      default: b = klo[1];
    endcase
    return b;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [15:0]      hold_q, hold_d;
  logic [1:0]       sel_q, sel_d;
  logic             se_q, se_d;
  logic             si_q, si_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             sat_q, sat_d;

  logic [KW-1:0]    k_inc;
  logic [1:0]       k_lo, k_inc_lo;

  assign k_inc    = k_q + 1'b1;
  assign k_lo     = 2'(k_q);
  assign k_inc_lo = 2'(k_inc);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    hold_d  = hold_q;
    sel_d   = sel_q;
    se_d    = se_q;
    si_d    = si_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sat_d   = sat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          k_d     = '0;
          hold_d  = hold_cycles;
          sel_d   = pattern_sel;
          err_d   = '0;
          sat_d   = 1'b0;
          se_d    = 1'b1;
          si_d    = pattern_bit(pattern_sel, 2'b00);
          busy_d  = 1'b1;
        end
      end

      StLoad: begin
        if (k_q == KLast) begin
          k_d  = '0;
          si_d = 1'b0;
          if (hold_q == 16'd0) begin
            state_d = StUnload;
          end else begin
            state_d = StHold;
            se_d    = 1'b0;
          end
        end else begin
          k_d  = k_inc;
          si_d = pattern_bit(sel_q, k_inc_lo);
        end
      end

      StHold: begin
        hold_d = hold_q - 16'd1;
        if (hold_q == 16'd1) begin
          state_d = StUnload;
          se_d    = 1'b1;
        end
      end

      StUnload: begin
        // First bit loaded sits in the tail flop, so unload index k matches load index k.
        if ((chain_so != pattern_bit(sel_q, k_lo)) && (err_q != CntMax)) begin
          err_d = err_q + 1'b1;
          if (err_d == CntMax) begin
            sat_d = 1'b1;
          end
        end
        if (k_q == KLast) begin
          state_d = StDone;
          k_d     = '0;
          se_d    = 1'b0;
          done_d  = 1'b1;
        end else begin
          k_d = k_inc;
        end
      end

      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        se_d    = 1'b0;
        si_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      hold_q  <= '0;
      sel_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  assign chain_se = se_q;
  assign chain_si = si_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_q;
  assign err_sat  = sat_q;

endmodule

// File: tb/tb_seu_chain_ctrl.sv
// Directed bench for seu_chain_ctrl: two instances (16-bit and 2-bit counters) on an 8-flop
// chain model with fault injection.
module tb_seu_chain_ctrl;
  localparam int L = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [1:0]  psel;
  logic [15:0] hold;

  logic se0, si0, so0, busy0, done0, sat0;
  logic [15:0] err0;
  logic se1, si1, so1, busy1, done1, sat1;
  logic [1:0] err1;

  logic [7:0] ch0 = 8'h00;
  logic [7:0] ch1 = 8'h00;
  logic [7:0] inj = 8'h00;

  int errors = 0;
  int checks = 0;

  assign so0 = ch0[7];
  assign so1 = ch1[7];

  // Chain model: head at bit 0, tail at bit 7; inj flips bits at the next edge.
  always @(posedge clk) begin
    ch0 <= (se0 ? {ch0[6:0], si0} : ch0) ^ inj;
    ch1 <= (se1 ? {ch1[6:0], si1} : ch1) ^ inj;
  end

  seu_chain_ctrl #(.CHAIN_LEN(L), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(psel), .hold_cycles(hold),
    .chain_se(se0), .chain_si(si0), .chain_so(so0), .busy(busy0), .done(done0),
    .err_cnt(err0), .err_sat(sat0)
  );

  seu_chain_ctrl #(.CHAIN_LEN(L), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pattern_sel(psel), .hold_cycles(hold),
    .chain_se(se1), .chain_si(si1), .chain_so(so1), .busy(busy1), .done(done1),
    .err_cnt(err1), .err_sat(sat1)
  );

  // Runs one transaction and records observations; cycle c is the c-th cycle after start edge.
  task automatic run_obs(input logic [1:0] sel, input logic [15:0] h, input logic [7:0] mask,
                         input bit disturb, output int done_c, output int done_n,
                         output int se_low, output logic [7:0] si_seq, output logic [15:0] e0,
                         output logic s0, output logic [1:0] e1, output logic s1,
                         output logic busy_c1, output logic c1_clear, output logic busy_end);
    done_c = -1; done_n = 0; se_low = 0; si_seq = 8'h00;
    e0 = 16'hFFFF; s0 = 1'b1; e1 = 2'b00; s1 = 1'b1; busy_c1 = 1'b0; c1_clear = 1'b0;
    @(negedge clk);
    psel = sel; hold = h; start = 1'b1;
    for (int c = 1; c <= 2 * L + int'(h) + 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start    = 1'b0;
        busy_c1  = busy0;
        c1_clear = (err0 == 16'd0) && !sat0 && (err1 == 2'd0) && !sat1;
      end
      inj = (c == L + 1 && h != 16'd0) ? mask : 8'h00;
      if (c <= L) si_seq[c-1] = si0;
      if (busy0 && !se0 && !done0) se_low++;
      if (disturb && c == 3) begin
        start = 1'b1; psel = ~sel; hold = h + 16'd3;
      end
      if (disturb && c == 4) start = 1'b0;
      if (done0) begin
        done_n++;
        if (done_c < 0) begin
          done_c = c; e0 = err0; s0 = sat0; e1 = err1; s1 = sat1;
          if (disturb) start = 1'b1;
        end
      end
      if (done_c > 0 && c == done_c + 1) start = 1'b0;
    end
    busy_end = busy0;
  endtask

  int dc, dn, sl;
  logic [7:0] sq;
  logic [15:0] e0v;
  logic [1:0] e1v;
  logic s0v, s1v, bc1, clr, bend;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; psel = 2'd0; hold = 16'd0;
    repeat (3) @(negedge clk);
    checks++; if ({se0, si0, busy0, done0, sat0} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {se0, si0, busy0, done0, sat0}); end
    checks++; if (err0 !== 16'd0) begin errors++;
      $display("FAIL reset_err0: got %0d expected 0", err0); end
    checks++; if ({se1, si1, busy1, done1, sat1, err1} !== 7'b0) begin errors++;
      $display("FAIL reset_dut1: got %b expected 0000000", {se1, si1, busy1, done1, sat1, err1}); end
    rst = 1'b0;
  endtask

  task automatic test_alt_pattern();
    run_obs(2'd2, 16'd5, 8'h00, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (sq !== 8'hAA) begin errors++;
      $display("FAIL alt_si_seq: got %h expected aa", sq); end
    checks++; if (sl !== 5) begin errors++;
      $display("FAIL alt_hold_len: got %0d expected 5", sl); end
    checks++; if (dc !== 22) begin errors++;
      $display("FAIL alt_done_cycle: got %0d expected 22", dc); end
    checks++; if (dn !== 1) begin errors++;
      $display("FAIL alt_done_count: got %0d expected 1", dn); end
    checks++; if (e0v !== 16'd0) begin errors++;
      $display("FAIL alt_err: got %0d expected 0", e0v); end
    checks++; if (bc1 !== 1'b1 || bend !== 1'b0) begin errors++;
      $display("FAIL alt_busy: got %b%b expected 10", bc1, bend); end
  endtask

  task automatic test_single_upset();
    run_obs(2'd1, 16'd3, 8'h10, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (sq !== 8'hFF) begin errors++;
      $display("FAIL upset_si_seq: got %h expected ff", sq); end
    checks++; if (e0v !== 16'd1 || s0v !== 1'b0) begin errors++;
      $display("FAIL upset_err: got %0d/%b expected 1/0", e0v, s0v); end
    checks++; if (dc !== 20) begin errors++;
      $display("FAIL upset_done_cycle: got %0d expected 20", dc); end
  endtask

  task automatic test_no_hold();
    run_obs(2'd3, 16'd0, 8'h00, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (sq !== 8'hCC) begin errors++;
      $display("FAIL nohold_si_seq: got %h expected cc", sq); end
    checks++; if (sl !== 0) begin errors++;
      $display("FAIL nohold_hold_len: got %0d expected 0", sl); end
    checks++; if (dc !== 17) begin errors++;
      $display("FAIL nohold_done_cycle: got %0d expected 17", dc); end
    checks++; if (e0v !== 16'd0) begin errors++;
      $display("FAIL nohold_err: got %0d expected 0", e0v); end
  endtask

  task automatic test_saturation();
    run_obs(2'd0, 16'd4, 8'hFF, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (e0v !== 16'd8 || s0v !== 1'b0) begin errors++;
      $display("FAIL sat_wide_err: got %0d/%b expected 8/0", e0v, s0v); end
    checks++; if (e1v !== 2'd3 || s1v !== 1'b1) begin errors++;
      $display("FAIL sat_narrow_err: got %0d/%b expected 3/1", e1v, s1v); end
    checks++; if (err1 !== 2'd3 || sat1 !== 1'b1) begin errors++;
      $display("FAIL sat_hold_idle: got %0d/%b expected 3/1", err1, sat1); end
    run_obs(2'd0, 16'd2, 8'h00, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (clr !== 1'b1) begin errors++;
      $display("FAIL sat_clear_on_start: got %b expected 1", clr); end
    checks++; if (e1v !== 2'd0 || s1v !== 1'b0 || dc !== 19) begin errors++;
      $display("FAIL sat_rerun: got %0d/%b/%0d expected 0/0/19", e1v, s1v, dc); end
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    int nbusy;
    @(negedge clk);
    psel = 2'd0; hold = 16'd2; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      inj = (c == L + 1) ? 8'hFF : 8'h00;
    end
    checks++; if (err0 !== 16'd3) begin errors++;
      $display("FAIL rst_pre_err: got %0d expected 3", err0); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy0, se0, done0} !== 3'b000 || err0 !== 16'd0) begin errors++;
      $display("FAIL rst_mid_outputs: got %b err=%0d expected 000 err=0",
               {busy0, se0, done0}, err0); end
    ndone = 0; nbusy = 0;
    repeat (30) begin
      @(negedge clk);
      if (done0) ndone++;
      if (busy0) nbusy++;
    end
    checks++; if (ndone !== 0 || nbusy !== 0) begin errors++;
      $display("FAIL rst_no_done: got done=%0d busy=%0d expected 0/0", ndone, nbusy); end
    run_obs(2'd2, 16'd1, 8'h00, 1'b0, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (dc !== 18 || dn !== 1 || e0v !== 16'd0 || sq !== 8'hAA) begin errors++;
      $display("FAIL rst_rerun: got dc=%0d dn=%0d err=%0d si=%h expected 18/1/0/aa",
               dc, dn, e0v, sq); end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    logic b18, b19;
    run_obs(2'd2, 16'd5, 8'h00, 1'b1, dc, dn, sl, sq, e0v, s0v, e1v, s1v, bc1, clr, bend);
    checks++; if (sq !== 8'hAA || sl !== 5) begin errors++;
      $display("FAIL b2b_captured: got si=%h hold=%0d expected aa/5", sq, sl); end
    checks++; if (dc !== 22 || dn !== 1 || bend !== 1'b0) begin errors++;
      $display("FAIL b2b_ignored_start: got dc=%0d dn=%0d busy=%b expected 22/1/0", dc, dn, bend); end
    @(negedge clk);
    psel = 2'd3; hold = 16'd0; start = 1'b1;
    d1 = -1; d2 = -1; b18 = 1'b1; b19 = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 18) b18 = busy0;
      if (c == 19) begin
        b19 = busy0; start = 1'b0;
      end
      if (done0 && d1 < 0) d1 = c;
      else if (done0 && d2 < 0) d2 = c;
    end
    checks++; if (d1 !== 17 || b18 !== 1'b0 || b19 !== 1'b1) begin errors++;
      $display("FAIL held_start_restart: got d1=%0d b18=%b b19=%b expected 17/0/1", d1, b18, b19); end
    checks++; if (d2 !== 35 || err0 !== 16'd0) begin errors++;
      $display("FAIL held_start_second_run: got d2=%0d err=%0d expected 35/0", d2, err0); end
  endtask

  initial begin
    test_reset();
    test_alt_pattern();
    test_single_upset();
    test_no_hold();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seu_chain_ctrl.md
# seu_chain_ctrl

Sequencer for single-event-upset (SEU) characterization of a scan chain built from the library's D flip-flops. It shifts a known pattern into the chain, holds the chain static for a programmable exposure window, then shifts the chain out. While shifting out, it compares every bit against the expected pattern and counts mismatches. It sits between the test-chip host interface and the device-under-test flop chain.

## Interface
- CHAIN_LEN, 64, number of flops in the chain under test (≥2)
- CNT_W, 16, width of the mismatch counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- pattern_sel  in  2  pattern select, captured at start: 0 = all 0, 1 = all 1, 2 = k[0] (0101…), 3 = k[1] (0011…), where k is the bit index
- hold_cycles  in  16  exposure length in cycles, captured at start
- chain_se  out  1  shift enable to chain; chain holds when 0
- chain_si  out  1  serial data into chain head
- chain_so  in  1  serial data from chain tail (combinational from last flop)
- busy  out  1  high in LOAD, HOLD, UNLOAD, DONE
- done  out  1  one-cycle pulse at end of run
- err_cnt  out  CNT_W  mismatch count of the current or last run
- err_sat  out  1  sticky; set when err_cnt saturates

## Operation
- States and transitions:
  - IDLE → LOAD when start = 1.
  - LOAD → HOLD after CHAIN_LEN cycles, or LOAD → UNLOAD directly if the captured hold value is 0.
  - HOLD → UNLOAD after the captured hold_cycles cycles.
  - UNLOAD → DONE after CHAIN_LEN cycles.
  - DONE → IDLE after 1 cycle.
- Accepting start:
  - Captures pattern_sel and hold_cycles.
  - Clears err_cnt and err_sat.
  - Clears the bit index k.
- LOAD:
  - chain_se = 1.
  - chain_si = pattern(k) for k = 0 … CHAIN_LEN-1, one bit per cycle.
- HOLD:
  - chain_se = 0, chain_si = 0.
  - A down-counter runs the exposure window.
- UNLOAD:
  - chain_se = 1 and chain_si = 0.
  - In UNLOAD cycle k, chain_so is sampled at the clock edge and compared against pattern(k). The bit loaded first emerges first.
  - Each mismatch increments err_cnt by 1.
- Saturation: at 2^CNT_W − 1, err_cnt stops incrementing and err_sat = 1. Both hold until the next accepted start or reset.
- Ignored inputs: start is ignored in every state except IDLE. pattern_sel and hold_cycles changes after capture have no effect on the run.
- err_cnt is readable at all times. Its final value is stable from the done cycle until the next accepted start.
- Reset at any time, including mid-run:
  - State returns to IDLE; the run is aborted.
  - No done pulse is issued.
  - All outputs take their reset values.

## Timing
- Reset values: chain_se = 0, chain_si = 0, busy = 0, done = 0, err_cnt = 0, err_sat = 0. Internal counters and captured registers are 0.
- start is sampled high at edge t:
  - Edges t+1 … t+CHAIN_LEN are LOAD shifts.
  - Next come H cycles of HOLD, then CHAIN_LEN UNLOAD sampling edges.
  - done is high for the single cycle after the last UNLOAD edge, at cycle t+2·CHAIN_LEN+H+1.
- busy rises the cycle after start is accepted. It falls the cycle after done.
- A start asserted in the done cycle is ignored. A start held high into IDLE is accepted on the first IDLE cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- The mismatch update is visible on err_cnt one cycle after the sampling edge. The final increment is visible in the done cycle.
- hold_cycles = 0xFFFF gives 65535 HOLD cycles; no wrap.

## Test plan
- Use CHAIN_LEN = 8. Bench models the chain as an 8-bit shift register with error injection.
- Scenario 1: pattern_sel = 2, hold_cycles = 5, no injection → si sequence 0,1,0,1,0,1,0,1; se low for exactly 5 cycles; done at t+22; err_cnt = 0.
- Scenario 2: pattern_sel = 1, hold_cycles = 3, flip flop 4 during HOLD → err_cnt = 1 at done; err_sat = 0.
- Scenario 3: pattern_sel = 3, hold_cycles = 0 → no HOLD cycles; UNLOAD immediately follows LOAD; done at t+17; err_cnt = 0.
- Scenario 4: CNT_W = 2, pattern_sel = 0, invert the whole chain during HOLD → 8 mismatches; err_cnt saturates at 3; err_sat = 1. The next start clears both.
- Scenario 5: assert rst in UNLOAD cycle 3 → next cycle busy = 0, se = 0, err_cnt = 0; no done. A following start runs normally.
- Scenario 6: pulse start in LOAD and in the done cycle, and change pattern_sel and hold_cycles mid-run → no effect; run matches the captured values. A start held high across done begins a new run on the first IDLE cycle.
